if_fetch_unit: RTL

Instruction-fetch initiator for the IF stage: owns the program counter, issues word-aligned fetch requests to the instruction memory, and presents fetched instructions with their PC to the IF/ID boundary under a valid/stall handshake. It absorbs the instruction memory's one-cycle synchronous read latency with a one-entry skid buffer. It squashes in-flight fetches on a branch/jump redirect.

---
 rtl/if_pkg.sv | 22 ++
 rtl/fetch_skid_buffer.sv | 31 +++
 rtl/if_fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch entries pair an instruction word with the byte address it came from.
package if_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = ~XLEN'(PC_STEP - 1);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instn;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Sequential next address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that could not enter the
// IF output register. Load wins over drain so a refill in the drain cycle sticks.
module fetch_skid_buffer
    import if_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_drain,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_entry
);

    fetch_entry_t r_entry;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_entry <= '0;
        end else if (i_flush) begin
            r_entry.valid <= 1'b0;
        end else if (i_load) begin
            r_entry <= i_entry;
        end else if (i_drain) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch initiator: owns the PC, issues one word fetch per cycle and
// presents responses to ID under a valid/stall handshake with a one-entry skid.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_pc,
    input  logic [XLEN-1:0] i_imem_instn,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_instn,
    output logic [XLEN-1:0] o_if_pc,
    output logic [XLEN-1:0] o_if_nextpc
);

    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    fetch_entry_t    r_out;
    logic [XLEN-1:0] r_out_nextpc;

    logic            w_req;
    logic            w_out_ready;
    logic            w_skid_load;
    logic            w_skid_drain;
    fetch_entry_t    w_resp;
    fetch_entry_t    w_skid;
    fetch_entry_t    w_out_next;

    // Requests stop during stall, so at most one response is ever outstanding.
    assign w_req       = !i_reset && !i_redirect && !i_stall;
    assign w_out_ready = !r_out.valid || !i_stall;

    assign w_resp = '{valid: r_inflight, instn: i_imem_instn, pc: r_inflight_pc};

    // Skid drains first to keep program order; a response arriving meanwhile takes its place.
    assign w_skid_drain = w_out_ready && w_skid.valid;
    assign w_skid_load  = r_inflight && (!w_out_ready || w_skid.valid);
    assign w_out_next   = w_skid.valid ? w_skid : w_resp;

    fetch_skid_buffer u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_redirect),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_entry (w_resp),
        .o_entry (w_skid)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_out         <= '0;
            r_out_nextpc  <= '0;
        end else if (i_redirect) begin
            // Response landing this cycle belongs to the squashed path.
            r_pc       <= i_redirect_pc & PC_ALIGN_MASK;
            r_inflight <= 1'b0;
            r_out.valid <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc          <= pc_next(r_pc);
                r_inflight_pc <= r_pc;
            end
            if (w_out_ready) begin
                r_out.valid <= w_out_next.valid;
                if (w_out_next.valid) begin
                    r_out.instn  <= w_out_next.instn;
                    r_out.pc     <= w_out_next.pc;
                    r_out_nextpc <= pc_next(w_out_next.pc);
                end
            end
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_pc   = r_pc;
    assign o_if_valid  = r_out.valid;
    assign o_if_instn  = r_out.instn;
    assign o_if_pc     = r_out.pc;
    assign o_if_nextpc = r_out_nextpc;

endmodule
